// File: rtl/mem_pkg.sv
// Shared encodings and request payload for the memory-access stage.
package mem_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned WB_W  = 3;

    // Access size encodings; 2'd3 behaves as a word.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // FSM state encoding.
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_WAIT = 1'b1;

    // Everything needed to drive or complete one memory request.
    typedef struct packed {
        logic              we;
        logic [1:0]        size;
        logic              sign_ext;
        logic [WB_W-1:0]   wb;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [REG_W-1:0]  rd_rt;
        logic [XLEN-1:0]   pc;
    } mem_req_t;

    // Natural alignment check for an access of the given size.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        logic ok;
        case (size)
            SZ_BYTE:       ok = 1'b1;
            SZ_HALF:       ok = ~off[0];
            SZ_WORD, 2'd3: ok = (off == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_align.sv
// Extracts and extends a byte/half/word from a 32-bit read word.
module load_align
    import mem_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      offset_i,
    input  logic [1:0]      size_i,
    input  logic            sign_ext_i,
    output logic [XLEN-1:0] rd_o
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    // Lane select followed by zero/sign extension.
    always_comb begin
        byte_c = rdata_i[{offset_i, 3'b000} +: 8];
        half_c = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            SZ_BYTE:       rd_o = {{24{sign_ext_i & byte_c[7]}}, byte_c};
            SZ_HALF:       rd_o = {{16{sign_ext_i & half_c[15]}}, half_c};
            SZ_WORD, 2'd3: rd_o = rdata_i;
            default:       rd_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: load/store against a ready-handshake data
// memory, producing the MEM/WB bundle combinationally each cycle.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [1:0]        size_i,
    input  logic              sign_ext_i,
    input  logic [WB_W-1:0]   wb_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [REG_W-1:0]  rd_rt_i,
    input  logic [XLEN-1:0]   pc_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [XLEN-1:0]   dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    input  logic              dmem_ready_i,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    output logic [WB_W-1:0]   wb_o,
    output logic [XLEN-1:0]   rd_o,
    output logic [XLEN-1:0]   alu_o,
    output logic [XLEN-1:0]   pc_o,
    output logic [REG_W-1:0]  rd_rt_o,
    output logic              stall_o,
    output logic              misalign_o,
    output logic              bus_err_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    mem_req_t         req_q, req_d;

    mem_req_t         req_in_c;
    mem_req_t         cur_c;
    logic             access_c;
    logic             aligned_c;
    logic [XLEN-1:0]  load_data_c;

    // Current request: live inputs while idle, the latch while waiting.
    always_comb begin
        req_in_c = '{we:       mem_write_i,
                     size:     size_i,
                     sign_ext: sign_ext_i,
                     wb:       wb_i,
                     addr:     addr_i,
                     wdata:    wdata_i,
                     rd_rt:    rd_rt_i,
                     pc:       pc_i};
        cur_c     = (state_q == ST_WAIT) ? req_q : req_in_c;
        access_c  = mem_read_i | mem_write_i;
        aligned_c = is_aligned(size_i, addr_i[1:0]);
    end

    // Store lane steering: byte enables and replicated write data.
    always_comb begin
        dmem_addr_o = {cur_c.addr[XLEN-1:2], 2'b00};
        case (cur_c.size)
            SZ_BYTE: begin
                dmem_be_o    = 4'(4'b0001 << cur_c.addr[1:0]);
                dmem_wdata_o = {4{cur_c.wdata[7:0]}};
            end
            SZ_HALF: begin
                dmem_be_o    = cur_c.addr[1] ? 4'b1100 : 4'b0011;
                dmem_wdata_o = {2{cur_c.wdata[15:0]}};
            end
            default: begin
                dmem_be_o    = 4'b1111;
                dmem_wdata_o = cur_c.wdata;
            end
        endcase
    end

    load_align u_load_align (
        .rdata_i    (dmem_rdata_i),
        .offset_i   (cur_c.addr[1:0]),
        .size_i     (cur_c.size),
        .sign_ext_i (cur_c.sign_ext),
        .rd_o       (load_data_c)
    );

    // Next-state and output logic for the IDLE/WAIT handshake FSM.
    always_comb begin
        state_d    = state_q;
        count_d    = '0;
        req_d      = req_q;
        dmem_req_o = 1'b0;
        dmem_we_o  = 1'b0;
        stall_o    = 1'b0;
        wb_o       = '0;
        rd_o       = '0;
        alu_o      = addr_i;
        pc_o       = pc_i;
        rd_rt_o    = rd_rt_i;
        misalign_o = 1'b0;
        bus_err_o  = 1'b0;

        if (!rst_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (!access_c) begin
                        wb_o = wb_i;
                    end else if (!aligned_c) begin
                        misalign_o = 1'b1;
                    end else begin
                        dmem_req_o = 1'b1;
                        dmem_we_o  = mem_write_i;
                        req_d      = req_in_c;
                        if (dmem_ready_i) begin
                            wb_o = wb_i;
                            rd_o = mem_write_i ? '0 : load_data_c;
                        end else begin
                            stall_o = 1'b1;
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    dmem_req_o = 1'b1;
                    dmem_we_o  = req_q.we;
                    alu_o      = req_q.addr;
                    pc_o       = req_q.pc;
                    rd_rt_o    = req_q.rd_rt;
                    if (dmem_ready_i) begin
                        wb_o    = req_q.wb;
                        rd_o    = req_q.we ? '0 : load_data_c;
                        state_d = ST_IDLE;
                    end else if (count_q == CNT_W'(TIMEOUT - 1)) begin
                        bus_err_o = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        stall_o = 1'b1;
                        count_d = count_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, wait counter and request latch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            req_q   <= req_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: per-instruction reference model pushes
// expected per-cycle outputs; a negedge monitor pops and compares.
module tb_mem_stage;

    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0, sign_ext = 1'b0;
    logic [1:0]  size = '0;
    logic [2:0]  wb = '0;
    logic [31:0] addr = '0, wdata = '0, pc = '0, rdata = '0;
    logic [4:0]  rd_rt = '0;
    logic        ready = 1'b0;

    logic        dmem_req, dmem_we, stall, misalign, bus_err;
    logic [31:0] dmem_addr, dmem_wdata, rd_out, alu_out, pc_out;
    logic [3:0]  dmem_be;
    logic [2:0]  wb_out;
    logic [4:0]  rd_rt_out;

    mem_stage #(.TIMEOUT(T)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .mem_read_i   (mem_read),
        .mem_write_i  (mem_write),
        .size_i       (size),
        .sign_ext_i   (sign_ext),
        .wb_i         (wb),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .rd_rt_i      (rd_rt),
        .pc_i         (pc),
        .dmem_req_o   (dmem_req),
        .dmem_we_o    (dmem_we),
        .dmem_addr_o  (dmem_addr),
        .dmem_be_o    (dmem_be),
        .dmem_wdata_o (dmem_wdata),
        .dmem_ready_i (ready),
        .dmem_rdata_i (rdata),
        .wb_o         (wb_out),
        .rd_o         (rd_out),
        .alu_o        (alu_out),
        .pc_o         (pc_out),
        .rd_rt_o      (rd_rt_out),
        .stall_o      (stall),
        .misalign_o   (misalign),
        .bus_err_o    (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk_req;   bit req;
        bit          chk_store; logic [31:0] daddr; logic [3:0] be; logic [31:0] dwd;
        bit          chk_wb;    logic [2:0] wb;
        bit          chk_rd;    logic [31:0] rd;
        bit          chk_pass;  logic [31:0] alu; logic [31:0] pc; logic [4:0] rdrt;
        logic        stall, mis, berr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare every presented cycle against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall", 32'(stall), 32'(e.stall));
                chk("misalign", 32'(misalign), 32'(e.mis));
                chk("bus_err", 32'(bus_err), 32'(e.berr));
                if (e.chk_req) chk("dmem_req", 32'(dmem_req), 32'(e.req));
                if (e.chk_store) begin
                    chk("dmem_we", 32'(dmem_we), 32'd1);
                    chk("dmem_addr", dmem_addr, e.daddr);
                    chk("dmem_be", 32'(dmem_be), 32'(e.be));
                    chk("dmem_wdata", dmem_wdata, e.dwd);
                end
                if (e.chk_wb) chk("wb_out", 32'(wb_out), 32'(e.wb));
                if (e.chk_rd) chk("rd", rd_out, e.rd);
                if (e.chk_pass) begin
                    chk("alu_out", alu_out, e.alu);
                    chk("pc_out", pc_out, e.pc);
                    chk("rd_rt_out", 32'(rd_rt_out), 32'(e.rdrt));
                end
            end
        end
    end

    // Reference: extracted load value from plain shifts and arithmetic.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] sz, input logic sx);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (w >> (8 * a[1:0])) & 32'hFF;
            if (sx && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (w >> (16 * a[1])) & 32'hFFFF;
            if (sx && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic bit ref_aligned(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 1'b1;
        if (sz == 2'd1) return (a % 2) == 0;
        return (a % 4) == 0;
    endfunction

    // Runs one instruction; lat = cycle index at which memory answers,
    // rst_at = cycle index at which reset is pulsed (-1 for none).
    task automatic run_instr(input logic rd_en, input logic wr_en, input logic [1:0] sz,
                             input logic sx, input logic [2:0] wbv, input logic [31:0] a,
                             input logic [31:0] wd, input logic [4:0] rr, input logic [31:0] p,
                             input int lat, input int rst_at, input logic [31:0] word);
        exp_t e;
        bit   acc;
        int   k_end;
        acc = rd_en | wr_en;
        k_end = (lat <= int'(T)) ? lat : int'(T);
        if (!acc || !ref_aligned(sz, a)) k_end = 0;
        for (int k = 0; k <= k_end; k++) begin
            @(posedge clk); #1;
            rst = (k == rst_at);
            mem_read = rd_en; mem_write = wr_en; size = sz; sign_ext = sx;
            wb = wbv; addr = a; wdata = wd; rd_rt = rr; pc = p;
            ready = (k == lat);
            rdata = (k == lat) ? word : $urandom;
            e = '{default: '0};
            e.chk_req = 1'b1;
            if (k == rst_at) begin
                e.chk_wb = 1'b1; e.chk_rd = 1'b1;
                q.push_back(e);
                break;
            end
            if (!acc) begin
                e.chk_wb = 1'b1; e.wb = wbv; e.chk_rd = 1'b1;
                e.chk_pass = 1'b1; e.alu = a; e.pc = p; e.rdrt = rr;
            end else if (!ref_aligned(sz, a)) begin
                e.mis = 1'b1; e.chk_wb = 1'b1;
            end else begin
                e.req = 1'b1;
                if (wr_en) begin
                    e.chk_store = 1'b1;
                    e.daddr = a & ~32'd3;
                    if (sz == 2'd0) begin
                        e.be = 4'(32'd1 << a[1:0]); e.dwd = 32'(wd[7:0]) * 32'h0101_0101;
                    end else if (sz == 2'd1) begin
                        e.be = a[1] ? 4'd12 : 4'd3; e.dwd = 32'(wd[15:0]) * 32'h0001_0001;
                    end else begin
                        e.be = 4'd15; e.dwd = wd;
                    end
                end
                e.chk_wb = 1'b1;
                if (k < k_end) begin
                    e.stall = 1'b1;
                end else if (lat <= int'(T)) begin
                    e.wb = wbv; e.chk_rd = 1'b1;
                    e.rd = wr_en ? 32'd0 : ref_load(word, a, sz, sx);
                    e.chk_pass = 1'b1; e.alu = a; e.pc = p; e.rdrt = rr;
                end else begin
                    e.berr = 1'b1; e.chk_req = 1'b0; e.chk_rd = 1'b1;
                    e.chk_store = 1'b0;
                end
            end
            q.push_back(e);
        end
    endtask

    // Stimulus: reset, directed cases, then randomized instruction stream.
    initial begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            rst = 1'b1; mem_read = 1'b1; mem_write = 1'b0; size = 2'd2;
            addr = $urandom & ~32'd3; wb = 3'd7; ready = 1'b0;
            e = '{default: '0};
            e.chk_req = 1'b1; e.chk_wb = 1'b1; e.chk_rd = 1'b1;
            q.push_back(e);
        end
        run_instr(1, 0, 2'd2, 0, 3'd5, 32'h100, 32'h0, 5'd3, 32'h400, 0, -1, 32'hDEAD_BEEF);
        run_instr(1, 0, 2'd0, 1, 3'd6, 32'h103, 32'h0, 5'd4, 32'h404, 2, -1, 32'h8011_2233);
        run_instr(0, 1, 2'd1, 0, 3'd1, 32'h22, 32'h0000_ABCD, 5'd0, 32'h408, 0, -1, 32'h0);
        run_instr(1, 0, 2'd2, 0, 3'd7, 32'h101, 32'h0, 5'd5, 32'h40C, 0, -1, 32'h1234_5678);
        run_instr(1, 0, 2'd2, 0, 3'd7, 32'h200, 32'h0, 5'd6, 32'h410, 99, -1, 32'h0);
        run_instr(1, 0, 2'd1, 1, 3'd2, 32'h302, 32'h0, 5'd7, 32'h414, int'(T), -1, 32'h9ABC_0000);
        run_instr(1, 0, 2'd2, 0, 3'd3, 32'h300, 32'h0, 5'd8, 32'h418, 99, 2, 32'h0);
        run_instr(0, 0, 2'd2, 0, 3'd4, 32'h55, 32'h0, 5'd9, 32'h41C, 0, -1, 32'hFFFF_FFFF);
        run_instr(1, 0, 2'd0, 0, 3'd5, 32'h301, 32'h0, 5'd10, 32'h420, 0, -1, 32'h00C3_0000);
        for (int n = 0; n < 300; n++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            run_instr(op[0], op[1], 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)),
                      $urandom, $urandom_range(0, 6), -1, $urandom);
        end
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
